// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Brief    : Shared constants and helpers for the pipelined CLA adder.
//  Revision : 1.0  initial release
// ============================================================================
package cla_pkg;

    localparam int GROUP_MIN = 1;
    localparam int GROUP_MAX = 8;

    // One pipeline stage per lookahead group.
    function automatic int cla_ng(input int width, input int group);
        return width / group;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_pipe_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_adder_if
//  Brief    : Operand/result handshake bundle of the pipelined CLA adder.
//  Revision : 1.0  initial release
// ============================================================================
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Q;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, Q, cout, ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, Q, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
//  Module   : cla_group
//  Brief    : Combinational GROUP-bit carry-lookahead cell.
//  Revision : 1.0  initial release
// ============================================================================
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;
    logic             w_acc;
    logic             w_pp;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is a flat sum of products of g/p/ci, never of another carry.
    always_comb begin
        w_c    = '0;
        w_acc  = 1'b0;
        w_pp   = 1'b1;
        w_c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            w_acc = 1'b0;
            w_pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_acc = w_acc | (w_pp & w_g[j]);
                w_pp  = w_pp & w_p[j];
            end
            w_c[i+1] = w_acc | (w_pp & ci);
        end
    end

    assign s     = w_p ^ w_c[GROUP-1:0];
    assign co    = w_c[GROUP];
    assign c_msb = w_c[GROUP-1];

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_adder
//  Brief    : Pipelined carry-lookahead adder/subtractor, one group per stage,
//             valid/ready on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    cla_pipe_adder_if.slave  bus
);

    localparam int c_ng = cla_ng(WIDTH, GROUP);

    if ((WIDTH % GROUP) != 0 || GROUP < GROUP_MIN || GROUP > GROUP_MAX) begin : g_param_err
        $error("cla_pipe_adder: illegal WIDTH/GROUP combination");
    end

    logic [WIDTH-1:0] r_sum [1:c_ng];
    logic             r_c   [1:c_ng];
    logic             r_vld [1:c_ng];
    logic             r_ovf;

    logic             w_adv;
    logic             w_acc;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;
    logic             w_vin    [1:c_ng];
    logic [WIDTH-1:0] w_sum_in [1:c_ng];

    logic [GROUP-1:0] w_ga [0:c_ng-1];
    logic [GROUP-1:0] w_gb [0:c_ng-1];
    logic             w_gc [0:c_ng-1];
    logic [GROUP-1:0] w_s  [0:c_ng-1];
    logic             w_co [0:c_ng-1];
    logic             w_cm [0:c_ng-1];

    assign w_adv   = !r_vld[c_ng] || bus.out_ready;
    assign w_acc   = bus.in_valid && w_adv;
    assign w_b_eff = bus.sub ? ~bus.B : bus.B;
    assign w_c_eff = bus.sub | bus.Cin;

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[c_ng];
    assign bus.Q         = r_sum[c_ng];
    assign bus.cout      = r_c[c_ng];
    assign bus.ovf       = r_ovf;

    // Group 0 works straight off the ports; later groups off delayed operands.
    assign w_ga[0] = bus.A[GROUP-1:0];
    assign w_gb[0] = w_b_eff[GROUP-1:0];
    assign w_gc[0] = w_c_eff;

    if (c_ng > 1) begin : g_ops
        logic [WIDTH-1:0] r_a [1:c_ng-1];
        logic [WIDTH-1:0] r_b [1:c_ng-1];

        always_ff @(posedge clk) begin
            if (w_adv && w_vin[1]) begin
                r_a[1] <= bus.A;
                r_b[1] <= w_b_eff;
            end
            for (int s = 2; s < c_ng; s++) begin
                if (w_adv && w_vin[s]) begin
                    r_a[s] <= r_a[s-1];
                    r_b[s] <= r_b[s-1];
                end
            end
        end

        for (genvar gi = 1; gi < c_ng; gi++) begin : g_sel
            assign w_ga[gi] = r_a[gi][gi*GROUP +: GROUP];
            assign w_gb[gi] = r_b[gi][gi*GROUP +: GROUP];
            assign w_gc[gi] = r_c[gi];
        end
    end

    for (genvar gi = 0; gi < c_ng; gi++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .a     (w_ga[gi]),
            .b     (w_gb[gi]),
            .ci    (w_gc[gi]),
            .s     (w_s[gi]),
            .co    (w_co[gi]),
            .c_msb (w_cm[gi])
        );
    end

    always_comb begin
        w_vin[1] = w_acc;
        for (int s = 2; s <= c_ng; s++) begin
            w_vin[s] = r_vld[s-1];
        end
    end

    always_comb begin
        for (int s = 1; s <= c_ng; s++) begin
            w_sum_in[s] = '0;
        end
        w_sum_in[1][GROUP-1:0] = w_s[0];
        for (int s = 2; s <= c_ng; s++) begin
            w_sum_in[s]                       = r_sum[s-1];
            w_sum_in[s][(s-1)*GROUP +: GROUP] = w_s[s-1];
        end
    end

    // Data only loads behind a valid entry, so bubbles leave Q/cout/ovf untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 1; s <= c_ng; s++) begin
                r_vld[s] <= 1'b0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int s = 1; s <= c_ng; s++) begin
                r_vld[s] <= w_vin[s];
                if (w_vin[s]) begin
                    r_sum[s] <= w_sum_in[s];
                    r_c[s]   <= w_co[s-1];
                end
            end
            if (w_vin[c_ng]) begin
                r_ovf <= w_co[c_ng-1] ^ w_cm[c_ng-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_pipe_adder
//  Brief    : Self-checking bench: 16/4, 8/8 (single stage) and 32/8 adders
//             run side by side against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cla_pipe_adder;

    typedef struct {
        logic [31:0] q;
        logic        c;
        logic        o;
        int          cyc;
        int          st;
        bit          seen;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        s;
        logic [15:0] q;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv = 1'b0;
    logic        ordy0 = 1'b1;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        ci = 1'b0;
    logic        sb = 1'b0;

    int   npass = 0;
    int   ntot  = 0;
    int   cyc   = 0;
    int   stalls [3];
    exp_t sbq [3][$];
    logic prev_rst = 1'b1;
    vec_t vt [5];

    cla_pipe_adder_if #(.WIDTH(16)) if16 ();
    cla_pipe_adder_if #(.WIDTH(8))  if8  ();
    cla_pipe_adder_if #(.WIDTH(32)) if32 ();

    assign if16.in_valid  = iv;
    assign if16.A         = a32[15:0];
    assign if16.B         = b32[15:0];
    assign if16.Cin       = ci;
    assign if16.sub       = sb;
    assign if16.out_ready = ordy0;

    // The side instances never stall, so they accept exactly when the 16-bit one does.
    assign if8.in_valid   = iv && if16.in_ready;
    assign if8.A          = a32[7:0];
    assign if8.B          = b32[7:0];
    assign if8.Cin        = ci;
    assign if8.sub        = sb;
    assign if8.out_ready  = 1'b1;

    assign if32.in_valid  = iv && if16.in_ready;
    assign if32.A         = a32;
    assign if32.B         = b32;
    assign if32.Cin       = ci;
    assign if32.sub       = sb;
    assign if32.out_ready = 1'b1;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    cla_pipe_adder #(.WIDTH(8),  .GROUP(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else npass++;
    endtask

    // Reference: plain integer arithmetic, overflow from the true signed result.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s);
        longint one, mask, av, bv, bb, sum, sa, sbv, tru;
        exp_t   e;
        one  = 1;
        mask = (one << w) - 1;
        av   = longint'(a) & mask;
        bv   = longint'(b) & mask;
        bb   = s ? (~bv & mask) : bv;
        sum  = av + bb + (s ? one : longint'(c));
        sa   = ((av >> (w - 1)) & 1) != 0 ? av - (one << w) : av;
        sbv  = ((bv >> (w - 1)) & 1) != 0 ? bv - (one << w) : bv;
        tru  = s ? sa - sbv : sa + sbv + longint'(c);
        e.q    = 32'(sum & mask);
        e.c    = ((sum >> w) & 1) != 0;
        e.o    = (tru > (one << (w - 1)) - 1) || (tru < -(one << (w - 1)));
        e.cyc  = 0;
        e.st   = 0;
        e.seen = 1'b0;
        return e;
    endfunction

    task automatic mon(input int id, input int ng, input int w,
                       input logic ivl, input logic ir, input logic ov, input logic ordy,
                       input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                       input logic [31:0] q, input logic co, input logic of);
        exp_t e;
        if (!rst_n) begin
            sbq[id].delete();
            return;
        end
        if (!prev_rst) chk($sformatf("d%0d reset state", id), {ov, q, co, of}, 0);
        chk($sformatf("d%0d in_ready", id), ir, !ov || ordy);
        if (ov) begin
            if (sbq[id].size() == 0) begin
                chk($sformatf("d%0d unexpected out_valid", id), ov, 0);
            end else begin
                e = sbq[id][0];
                chk($sformatf("d%0d result", id), {q, co, of}, {e.q, e.c, e.o});
                if (!e.seen) begin
                    if (e.st == stalls[id]) chk($sformatf("d%0d latency", id), cyc - e.cyc, ng);
                    sbq[id][0].seen = 1'b1;
                end
                if (ordy) void'(sbq[id].pop_front());
                else stalls[id]++;
            end
        end
        if (ivl && ir) begin
            e     = model(w, a, b, c, s);
            e.cyc = cyc;
            e.st  = stalls[id];
            sbq[id].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        #2;
        mon(0, 4, 16, if16.in_valid, if16.in_ready, if16.out_valid, if16.out_ready,
            {16'd0, if16.A}, {16'd0, if16.B}, if16.Cin, if16.sub,
            {16'd0, if16.Q}, if16.cout, if16.ovf);
        mon(1, 1, 8, if8.in_valid, if8.in_ready, if8.out_valid, if8.out_ready,
            {24'd0, if8.A}, {24'd0, if8.B}, if8.Cin, if8.sub,
            {24'd0, if8.Q}, if8.cout, if8.ovf);
        mon(2, 4, 32, if32.in_valid, if32.in_ready, if32.out_valid, if32.out_ready,
            if32.A, if32.B, if32.Cin, if32.sub, if32.Q, if32.cout, if32.ovf);
        prev_rst = rst_n;
    end

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        a32 = {16'd0, v.a}; b32 = {16'd0, v.b}; ci = v.ci; sb = v.s; iv = 1'b1; ordy0 = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3 chk("vec early out_valid", if16.out_valid, 0);
        @(negedge clk);
        #3;
        chk("vec out_valid", if16.out_valid, 1);
        chk("vec Q", if16.Q, v.q);
        chk("vec cout", if16.cout, v.co);
        chk("vec ovf", if16.ovf, v.ov);
        @(negedge clk);
        #3 chk("vec single-cycle out_valid", if16.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  hold;
        vt[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) stalls[i] = 0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #3 chk("post-reset out_valid", if16.out_valid, 0);
        chk("post-reset in_ready", if16.in_ready, 1);

        for (int i = 0; i < 5; i++) apply_vec(vt[i]);

        // Back-to-back random traffic with a flaky consumer.
        n    = 0;
        hold = 1'b0;
        for (int k = 0; k < 400 && n < 20; k++) begin
            @(negedge clk);
            if (!hold) begin
                a32 = $urandom; b32 = $urandom;
                ci  = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            end
            iv    = 1'b1;
            ordy0 = 1'($urandom_range(0, 1));
            #1;
            if (if16.in_ready) begin n++; hold = 1'b0; end
            else hold = 1'b1;
        end
        @(negedge clk);
        iv = 1'b0; ordy0 = 1'b1;
        chk("random ops accepted", n, 20);
        repeat (8) @(negedge clk);

        // Three ops in flight, then a one-edge reset.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; ci = 1'b0; sb = 1'($urandom_range(0, 1));
            iv = 1'b1; ordy0 = 1'b1;
        end
        @(negedge clk);
        iv = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("mid-reset out_valid", if16.out_valid, 0);
        chk("mid-reset Q/cout/ovf", {if16.Q, if16.cout, if16.ovf}, 0);
        repeat (6) @(negedge clk);
        apply_vec(vt[0]);

        repeat (6) @(negedge clk);
        #3;
        for (int i = 0; i < 3; i++) chk($sformatf("d%0d drained", i), sbq[i].size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
